// File: rtl/periph_bus_pkg.sv
// Shared constants for the Wishbone-to-peripheral bridge.
// FSM state codes and the address field positions used for decoding.
package periph_bus_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SETUP  = 3'd1;
    localparam logic [2:0] ST_STROBE = 3'd2;
    localparam logic [2:0] ST_ACK    = 3'd3;
    localparam logic [2:0] ST_BAD    = 3'd4;

    localparam int SLOT_MSB = 7;
    localparam int SLOT_LSB = 4;
    localparam int REG_MSB  = 3;
    localparam int REG_LSB  = 2;
    localparam int WIN_MSB  = 31;
    localparam int WIN_LSB  = 8;

endpackage

// File: rtl/periph_rdmux.sv
// Read-data lane selector: picks the 8-bit lane of the addressed slot.
// Ports: databo (all lanes), slot (4-bit index), data (selected byte, 0 if out of range).
module periph_rdmux
    import periph_bus_pkg::*;
#(
    parameter int NPERIPH = 4
) (
    input  logic [8*NPERIPH-1:0] databo,
    input  logic [3:0]           slot,
    output logic [7:0]           data
);

    always_comb begin
        data = 8'h00;
        for (int k = 0; k < NPERIPH; k++) begin
            if (slot == 4'(k)) begin
                data = databo[8*k +: 8];
            end
        end
    end

endmodule

// File: rtl/periph_bus_bridge.sv
// Wishbone classic slave bridging 32-bit accesses onto the 8-bit peripheral bus.
// Ports: clk, rst (async active-low), wbs_* slave bus, p_* peripheral bus.
// Build option BRIDGE_ERR_EN: invalid hits raise wbs_err_o instead of a zero-data ack.
module periph_bus_bridge
    import periph_bus_pkg::*;
#(
    parameter int          NPERIPH = 4,
    parameter logic [31:0] BASE    = 32'h3000_0000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wbs_cyc_i,
    input  logic                 wbs_stb_i,
    input  logic                 wbs_we_i,
    input  logic [3:0]           wbs_sel_i,
    input  logic [31:0]          wbs_adr_i,
    input  logic [31:0]          wbs_dat_i,
    output logic                 wbs_ack_o,
    output logic                 wbs_err_o,
    output logic [31:0]          wbs_dat_o,
    output logic [1:0]           p_address,
    output logic [7:0]           p_databi,
    output logic                 p_wr,
    output logic [NPERIPH-1:0]   p_cen,
    input  logic [8*NPERIPH-1:0] p_databo
);

    logic [2:0]         state;
    logic [3:0]         slot;
    logic [3:0]         req_slot;
    logic               hit;
    logic               valid;
    logic [7:0]         rd_byte;
    logic [NPERIPH-1:0] cen_dec;
    logic               unused_bits;

    assign req_slot = wbs_adr_i[SLOT_MSB:SLOT_LSB];
    assign hit = wbs_cyc_i & wbs_stb_i &
                 (wbs_adr_i[WIN_MSB:WIN_LSB] == BASE[WIN_MSB:WIN_LSB]);
    assign valid = (int'(req_slot) < NPERIPH) & wbs_sel_i[0];

    assign unused_bits = ^{wbs_sel_i[3:1], wbs_adr_i[1:0], wbs_dat_i[31:8]};

    always_comb begin
        cen_dec = '0;
        for (int k = 0; k < NPERIPH; k++) begin
            cen_dec[k] = (slot == 4'(k));
        end
    end

    periph_rdmux #(
        .NPERIPH(NPERIPH)
    ) u_rdmux (
        .databo(p_databo),
        .slot  (slot),
        .data  (rd_byte)
    );

`ifndef BRIDGE_ERR_EN
    assign wbs_err_o = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            slot      <= 4'h0;
            wbs_ack_o <= 1'b0;
`ifdef BRIDGE_ERR_EN
            wbs_err_o <= 1'b0;
`endif
            wbs_dat_o <= 32'h0;
            p_address <= 2'b00;
            p_databi  <= 8'h00;
            p_wr      <= 1'b0;
            p_cen     <= '0;
        end else begin
            wbs_ack_o <= 1'b0;
`ifdef BRIDGE_ERR_EN
            wbs_err_o <= 1'b0;
`endif
            unique case (state)
                ST_IDLE: begin
                    if (hit && valid) begin
                        slot      <= req_slot;
                        p_address <= wbs_adr_i[REG_MSB:REG_LSB];
                        p_databi  <= wbs_dat_i[7:0];
                        p_wr      <= wbs_we_i;
                        state     <= ST_SETUP;
                    end else if (hit) begin
`ifdef BRIDGE_ERR_EN
                        wbs_err_o <= 1'b1;
`else
                        wbs_ack_o <= 1'b1;
`endif
                        state     <= ST_BAD;
                    end
                end
                ST_SETUP: begin
                    // Abandoned cycle: never strobe the peripheral.
                    if (!wbs_cyc_i) begin
                        p_wr  <= 1'b0;
                        state <= ST_IDLE;
                    end else begin
                        p_cen <= cen_dec;
                        state <= ST_STROBE;
                    end
                end
                ST_STROBE: begin
                    // Peripheral updated its lane at the mid-cycle negedge.
                    p_cen     <= '0;
                    p_wr      <= 1'b0;
                    wbs_ack_o <= wbs_cyc_i;
                    wbs_dat_o <= (!p_wr && wbs_cyc_i) ?
                                 {24'h0, rd_byte} : 32'h0;
                    state     <= ST_ACK;
                end
                ST_ACK: begin
                    wbs_dat_o <= 32'h0;
                    state     <= ST_IDLE;
                end
                ST_BAD: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_periph_bus_bridge.sv
// Self-checking bench for periph_bus_bridge with a behavioural peripheral model.
// Directed cases followed by randomized accesses checked against a shadow register map.
module tb_periph_bus_bridge;

    localparam int          NP   = 4;
    localparam logic [31:0] BASE = 32'h3000_0000;
`ifdef BRIDGE_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            cyc = 1'b0;
    logic            stb = 1'b0;
    logic            we  = 1'b0;
    logic [3:0]      sel = 4'h0;
    logic [31:0]     adr = 32'h0;
    logic [31:0]     dat_i = 32'h0;
    logic            ack;
    logic            err;
    logic [31:0]     dat_o;
    logic [1:0]      p_address;
    logic [7:0]      p_databi;
    logic            p_wr;
    logic [NP-1:0]   p_cen;
    logic [8*NP-1:0] p_databo = '0;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] pregs   [NP][4] = '{default: 8'h00};
    logic [7:0] ref_mem [NP][4];

    always #5 clk = ~clk;

    periph_bus_bridge #(
        .NPERIPH(NP),
        .BASE   (BASE)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .wbs_cyc_i(cyc),
        .wbs_stb_i(stb),
        .wbs_we_i (we),
        .wbs_sel_i(sel),
        .wbs_adr_i(adr),
        .wbs_dat_i(dat_i),
        .wbs_ack_o(ack),
        .wbs_err_o(err),
        .wbs_dat_o(dat_o),
        .p_address(p_address),
        .p_databi (p_databi),
        .p_wr     (p_wr),
        .p_cen    (p_cen),
        .p_databo (p_databo)
    );

    // Peripherals latch writes and refresh their read lane on negedge.
    always @(negedge clk) begin
        for (int k = 0; k < NP; k++) begin
            if (p_cen[k]) begin
                if (p_wr) pregs[k][p_address] = p_databi;
                p_databo[8*k +: 8] = pregs[k][p_address];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic bus_idle();
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        sel = 4'h0; adr = 32'h0; dat_i = 32'h0;
    endtask

    // Entered and left #1 after a posedge.
    task automatic access(input string tag, input logic [31:0] a,
                          input logic w, input logic [3:0] s,
                          input logic [7:0] wd);
        int   slot_i;
        int   reg_i;
        bit   ok;
        int   lat;
        int   cen_cycles;
        logic [NP-1:0] cen_seen;
        logic [1:0]  addr_seen;
        logic [7:0]  dbi_seen;
        logic        wr_seen;
        logic [31:0] dat_seen;
        logic        err_seen;
        logic [7:0]  exp_rd;
        slot_i = int'(a[7:4]);
        reg_i  = int'(a[3:2]);
        ok     = (slot_i < NP) && s[0];
        exp_rd = 8'h00;
        if (ok && !w) exp_rd = ref_mem[slot_i][reg_i];
        lat = 0; cen_cycles = 0; cen_seen = '0;
        addr_seen = 2'b00; dbi_seen = 8'h00; wr_seen = 1'b0;
        dat_seen = 32'h0; err_seen = 1'b0;
        cyc = 1'b1; stb = 1'b1; we = w; sel = s; adr = a;
        dat_i = {$urandom, wd};
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk); #1;
            if (p_cen != '0) begin
                cen_cycles++;
                cen_seen  = cen_seen | p_cen;
                addr_seen = p_address;
                dbi_seen  = p_databi;
                wr_seen   = p_wr;
            end
            if (ack || err) begin
                lat = i; dat_seen = dat_o; err_seen = err;
                break;
            end
        end
        bus_idle();
        chk({tag, "_lat"}, 32'(lat), ok ? 32'd3 : 32'd1);
        chk({tag, "_err"}, 32'(err_seen), 32'(ERR_EN && !ok));
        chk({tag, "_dat"}, dat_seen, {24'h0, exp_rd});
        chk({tag, "_cen_n"}, 32'(cen_cycles), ok ? 32'd1 : 32'd0);
        chk({tag, "_cen"}, 32'(cen_seen),
            ok ? 32'(1) << slot_i : 32'd0);
        if (ok) begin
            chk({tag, "_paddr"}, 32'(addr_seen), 32'(reg_i));
            chk({tag, "_pwr"}, 32'(wr_seen), 32'(w));
            if (w) chk({tag, "_pdbi"}, 32'(dbi_seen), 32'(wd));
            if (w) ref_mem[slot_i][reg_i] = wd;
        end
        @(posedge clk); #1;
        chk({tag, "_resp1"}, 32'(ack | err), 32'd0);
    endtask

    initial begin
        int          seen_cen;
        int          seen_ack;
        logic [31:0] a;
        for (int k = 0; k < NP; k++)
            for (int r = 0; r < 4; r++) ref_mem[k][r] = 8'h00;

        bus_idle();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_cen", 32'(p_cen), 32'd0);
        chk("rst_pwr", 32'(p_wr), 32'd0);
        chk("rst_dat", dat_o, 32'd0);
        chk("rst_paddr", 32'(p_address), 32'd0);
        chk("rst_pdbi", 32'(p_databi), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;

        access("wr28", 32'h3000_0028, 1'b1, 4'h1, 8'hA5);
        access("wr0c", 32'h3000_000C, 1'b1, 4'h1, 8'h3C);
        access("rd0c", 32'h3000_000C, 1'b0, 4'h1, 8'h00);
        access("rd28", 32'h3000_0028, 1'b0, 4'hF, 8'h00);
        access("slot5", 32'h3000_0050, 1'b1, 4'h1, 8'h99);
        access("sel0", 32'h3000_0014, 1'b1, 4'hE, 8'h55);
        access("rd14", 32'h3000_0014, 1'b0, 4'h1, 8'h00);

        // Cycle abandoned in SETUP: no strobe, no ack, no write.
        cyc = 1'b1; stb = 1'b1; we = 1'b1; sel = 4'h1;
        adr = 32'h3000_0028; dat_i = 32'h0000_00FF;
        @(posedge clk); #1;
        chk("abort_pwr_setup", 32'(p_wr), 32'd1);
        bus_idle();
        seen_cen = 0; seen_ack = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (p_cen != '0) seen_cen++;
            if (ack || err) seen_ack++;
        end
        chk("abort_cen", 32'(seen_cen), 32'd0);
        chk("abort_ack", 32'(seen_ack), 32'd0);
        chk("abort_pwr", 32'(p_wr), 32'd0);
        access("abort_rd", 32'h3000_0028, 1'b0, 4'h1, 8'h00);

        // Reset during STROBE.
        cyc = 1'b1; stb = 1'b1; we = 1'b1; sel = 4'h1;
        adr = 32'h3000_0024; dat_i = 32'h0000_0077;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("mid_cen", 32'(p_cen), 32'h4);
        rst = 1'b0;
        #1;
        chk("arst_cen", 32'(p_cen), 32'd0);
        chk("arst_pwr", 32'(p_wr), 32'd0);
        chk("arst_ack", 32'(ack), 32'd0);
        bus_idle();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        access("post_rst_rd", 32'h3000_0024, 1'b0, 4'h1, 8'h00);
        access("post_rst_rd2", 32'h3000_0028, 1'b0, 4'h1, 8'h00);

        // Outside the window: nobody answers here.
        cyc = 1'b1; stb = 1'b1; we = 1'b1; sel = 4'h1;
        adr = 32'h4000_0000; dat_i = 32'h0000_0011;
        seen_cen = 0; seen_ack = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (p_cen != '0 || p_wr) seen_cen++;
            if (ack || err) seen_ack++;
        end
        bus_idle();
        chk("miss_p", 32'(seen_cen), 32'd0);
        chk("miss_resp", 32'(seen_ack), 32'd0);

        for (int i = 0; i < 40; i++) begin
            a = BASE;
            a[7:4] = 4'($urandom_range(0, 5));
            a[3:2] = 2'($urandom_range(0, 3));
            a[1:0] = 2'($urandom_range(0, 3));
            access("rnd", a, 1'($urandom),
                   {3'($urandom), 1'($urandom_range(0, 7) != 0)},
                   8'($urandom));
        end

        for (int k = 0; k < NP; k++) begin
            for (int r = 0; r < 4; r++) begin
                a = BASE;
                a[7:4] = 4'(k);
                a[3:2] = 2'(r);
                access("sweep", a, 1'b0, 4'h1, 8'h00);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
